div10_sched: RTL and testbench



---
 rtl/div10_sched_if.sv | 24 ++
 rtl/div10_sched.sv | 142 ++++++++++++++
 tb/tb_div10_sched.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/div10_sched_if.sv
// Requester-side handshake and result bus for the shared divide-by-10 BCD converter.
// The master drives requests and operands; the slave (scheduler) returns acks and results.
interface div10_sched_if #(
    parameter int DIGITS = 4
);
    logic [1:0]            req_i;
    logic [13:0]           num0_i;
    logic [13:0]           num1_i;
    logic [1:0]            ack_o;
    logic                  busy_o;
    logic [1:0]            done_o;
    logic [4*DIGITS-1:0]   digits_o;
    logic                  clamp_o;

    modport master (
        output req_i, num0_i, num1_i,
        input  ack_o, busy_o, done_o, digits_o, clamp_o
    );

    modport slave (
        input  req_i, num0_i, num1_i,
        output ack_o, busy_o, done_o, digits_o, clamp_o
    );
endinterface

// File: rtl/div10_sched.sv
// Round-robin scheduler sharing one combinational divide-by-10 between two requesters,
// producing DIGITS packed BCD digits per job (units first), one digit per clock.
module div10_sched #(
    parameter int DIGITS = 4,
    parameter int MAXVAL = 9999
) (
    input  logic          CLK,
    input  logic          RST_N,
    div10_sched_if.slave  bus
);

    localparam int          CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          BCD_W  = 4 * DIGITS;
    localparam logic [13:0] MAX14  = 14'(MAXVAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reciprocal multiply: floor(x*6554/2^16) equals x/10 for every x below 16384.
    function automatic logic [13:0] div10_quo(input logic [13:0] x);
        return 14'((27'(x) * 27'd6554) >> 16);
    endfunction

    function automatic logic [3:0] div10_rem(input logic [13:0] x, input logic [13:0] q);
        return 4'(x - q * 14'd10);
    endfunction

    function automatic logic [13:0] clamp_val(input logic [13:0] x);
        return (x > MAX14) ? MAX14 : x;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic               pclamp_q, pclamp_d;
    logic [1:0]         ack_q, ack_d;
    logic [1:0]         done_q, done_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic               clamp_q, clamp_d;

    logic [13:0]        work_q, work_d;
    logic [BCD_W-1:0]   buf_q, buf_d;

    logic               gnt;
    logic [13:0]        sel_num;
    logic [13:0]        quo;
    logic [3:0]         rem;

    // With both requests pending the one not served last wins.
    assign gnt     = (bus.req_i == 2'b10) | ((bus.req_i == 2'b11) & ~last_q);
    assign sel_num = gnt ? bus.num1_i : bus.num0_i;
    assign quo     = div10_quo(work_q);
    assign rem     = div10_rem(work_q, quo);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        pclamp_d = pclamp_q;
        ack_d    = 2'b00;
        done_d   = 2'b00;
        digits_d = digits_q;
        clamp_d  = clamp_q;
        work_d   = work_q;
        buf_d    = buf_q;

        case (state_q)
            IDLE: begin
                if (bus.req_i != 2'b00) begin
                    ack_d[gnt] = 1'b1;
                    owner_d    = gnt;
                    work_d     = clamp_val(sel_num);
                    pclamp_d   = (sel_num > MAX14);
                    cnt_d      = '0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                buf_d[4*int'(cnt_q) +: 4] = rem;
                work_d = quo;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                digits_d        = buf_q;
                clamp_d         = pclamp_q;
                done_d[owner_q] = 1'b1;
                last_d          = owner_q;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and visible outputs: cleared by reset, abandoning any job in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            pclamp_q <= 1'b0;
            ack_q    <= 2'b00;
            done_q   <= 2'b00;
            digits_q <= '0;
            clamp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            pclamp_q <= pclamp_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            digits_q <= digits_d;
            clamp_q  <= clamp_d;
        end
    end

    // Datapath: always loaded before use, so no reset needed.
    always_ff @(posedge CLK) begin
        work_q <= work_d;
        buf_q  <= buf_d;
    end

    assign bus.ack_o    = ack_q;
    assign bus.done_o   = done_q;
    assign bus.busy_o   = (state_q != IDLE);
    assign bus.digits_o = digits_q;
    assign bus.clamp_o  = clamp_q;

endmodule

// File: tb/tb_div10_sched.sv
// Directed bench for div10_sched with a cycle-level job model compared on every clock.
module tb_div10_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div10_sched_if bus ();

    div10_sched dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Job model: an accepted job finishes 5 edges later; the block is idle in between jobs.
    int          m_phase, m_timer, m_val, m_n;
    logic        m_last, m_owner, m_pclamp, m_g;
    logic [1:0]  e_ack, e_done;
    logic        e_busy, e_clamp;
    logic [15:0] e_dig;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_phase = 0; m_timer = 0; m_last = 1'b1; m_owner = 1'b0; m_pclamp = 1'b0;
            m_val = 0; e_ack = 2'b00; e_done = 2'b00; e_dig = 16'h0; e_clamp = 1'b0;
        end else begin
            e_ack  = 2'b00;
            e_done = 2'b00;
            if (m_phase == 0) begin
                if (bus.req_i != 2'b00) begin
                    m_g      = (bus.req_i == 2'b11) ? !m_last : bus.req_i[1];
                    m_n      = m_g ? int'(bus.num1_i) : int'(bus.num0_i);
                    m_pclamp = (m_n > 9999);
                    m_val    = m_pclamp ? 9999 : m_n;
                    e_ack[m_g] = 1'b1;
                    m_owner  = m_g;
                    m_phase  = 1;
                    m_timer  = 5;
                end
            end else begin
                m_timer--;
                if (m_timer == 0) begin
                    e_done[m_owner] = 1'b1;
                    e_dig   = to_bcd(m_val);
                    e_clamp = m_pclamp;
                    m_last  = m_owner;
                    m_phase = 0;
                end
            end
        end
        e_busy = (m_phase != 0);
        #1;
        chk("m_ack",    bus.ack_o,    e_ack);
        chk("m_done",   bus.done_o,   e_done);
        chk("m_busy",   bus.busy_o,   e_busy);
        chk("m_digits", bus.digits_o, e_dig);
        chk("m_clamp",  bus.clamp_o,  e_clamp);
    end

    task automatic wait_ack(output int c);
        c = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (bus.ack_o != 2'b00) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_chk++; n_err++;
            $display("FAIL ack_wait: got no ack expected ack within 20 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_done(output int c);
        c = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (bus.done_o != 2'b00) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_chk++; n_err++;
            $display("FAIL done_wait: got no done expected done within 20 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic job(input logic [1:0] r, input int n0, input int n1,
                       input logic [1:0] ea, input logic [15:0] dig, input logic cl);
        int ka, kd;
        @(negedge clk);
        bus.req_i = r; bus.num0_i = 14'(n0); bus.num1_i = 14'(n1);
        wait_ack(ka);
        chk("ack_lit", bus.ack_o, ea);
        chk("busy_at_ack", bus.busy_o, 1);
        @(negedge clk);
        bus.req_i = 2'b00; bus.num0_i = 14'h3fff; bus.num1_i = 14'h3fff;
        wait_done(kd);
        chk("latency",    kd - ka, 5);
        chk("done_lit",   bus.done_o, ea);
        chk("digits_lit", bus.digits_o, dig);
        chk("clamp_lit",  bus.clamp_o, cl);
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        int ka, kb, kd, prev;
        bus.req_i = 2'b00; bus.num0_i = '0; bus.num1_i = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ack",    bus.ack_o, 0);
        chk("rst_done",   bus.done_o, 0);
        chk("rst_busy",   bus.busy_o, 0);
        chk("rst_digits", bus.digits_o, 0);
        chk("rst_clamp",  bus.clamp_o, 0);
        @(negedge clk); rst_n = 1'b1;

        job(2'b01, 1234, 0, 2'b01, 16'h1234, 1'b0);
        job(2'b10, 0, 0,    2'b10, 16'h0000, 1'b0);
        job(2'b10, 0, 9999, 2'b10, 16'h9999, 1'b0);
        job(2'b01, 12000, 0, 2'b01, 16'h9999, 1'b1);
        job(2'b01, 42, 0,   2'b01, 16'h0042, 1'b0);
        job(2'b10, 0, 16383, 2'b10, 16'h9999, 1'b1);
        job(2'b01, 9, 0,    2'b01, 16'h0009, 1'b0);

        // Both requesting continuously: strict alternation starting with requester 0.
        do_reset();
        @(negedge clk);
        bus.req_i = 2'b11; bus.num0_i = 14'd1; bus.num1_i = 14'd2;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(ka);
            chk("rr_grant", bus.ack_o, (i % 2 != 0) ? 2 : 1);
            if (prev >= 0) chk("rr_spacing", ka - prev, 6);
            prev = ka;
            wait_done(kd);
            chk("rr_digits", bus.digits_o, (i % 2 != 0) ? 16'h0002 : 16'h0001);
        end
        @(negedge clk);
        bus.req_i = 2'b00;

        // Reset in the middle of a job discards it.
        @(negedge clk);
        bus.req_i = 2'b01; bus.num0_i = 14'd5678;
        wait_ack(ka);
        @(negedge clk); bus.req_i = 2'b00;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("midrst_busy",   bus.busy_o, 0);
        chk("midrst_done",   bus.done_o, 0);
        chk("midrst_digits", bus.digits_o, 0);
        chk("midrst_ack",    bus.ack_o, 0);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            chk("midrst_nodone", bus.done_o, 0);
        end
        job(2'b01, 5678, 0, 2'b01, 16'h5678, 1'b0);

        // A request raised during conversion waits for IDLE.
        @(negedge clk);
        bus.req_i = 2'b01; bus.num0_i = 14'd100;
        wait_ack(ka);
        @(negedge clk); bus.req_i = 2'b00;
        @(negedge clk); bus.req_i = 2'b10; bus.num1_i = 14'd77;
        wait_ack(kb);
        chk("defer_spacing", kb - ka, 6);
        chk("defer_grant",   bus.ack_o, 2);
        @(negedge clk); bus.req_i = 2'b00;
        wait_done(kd);
        chk("defer_digits", bus.digits_o, 16'h0077);
        chk("defer_done",   bus.done_o, 2);

        repeat (3) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
